eth_mii_tx_framer: RTL and testbench



---
 rtl/eth_mii_tx_framer.sv | 248 ++++++++++++++++++++++++
 tb/tb_eth_mii_tx_framer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mii_tx_framer.sv
// Purpose: Ethernet MII TX framer. Emits preamble/SFD, payload, zero pad and CRC-32 FCS as nibbles, then holds the IFG.
// Latency: the first preamble nibble appears one cycle after in_valid is seen in IDLE. Throughput is one byte per two cycles.
// Backpressure: in_ready is a registered one-cycle pulse per byte. No byte when one is due aborts the frame with tx_er (underrun).
// Ports: clk/resetn (async active-low); in_valid/in_data/in_last/in_ready byte stream in;
//        tx_data/tx_en/tx_er MII out; busy, sticky underrun, frame_cnt status; clr_status clears status.
module eth_mii_tx_framer #(
    parameter int MIN_BYTES  = 60,
    parameter int IFG_CYCLES = 24
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [3:0]  tx_data,
    output logic        tx_en,
    output logic        tx_er,
    output logic        busy,
    output logic        underrun,
    input  logic        clr_status,
    output logic [15:0] frame_cnt
);
    localparam int          CNT_MAX  = (IFG_CYCLES > 16) ? IFG_CYCLES : 16;
    localparam int          CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [10:0] BCNT_MAX = 11'h7FF;

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_PAYLOAD, S_PAD, S_FCS, S_UNDERRUN, S_IFG
    } state_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // state_q names what is on the MII pins this cycle; every output register
    // is loaded together with the state that it belongs to.
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               phase_q, phase_d;      // 0: low nibble on pins, 1: high nibble
    logic [3:0]         hold_hi_q, hold_hi_d;  // high nibble of the byte in flight
    logic               last_q, last_d;
    logic [31:0]        crc_q, crc_d;
    logic [10:0]        bcnt_q, bcnt_d;
    logic               in_ready_q, in_ready_d;
    logic [3:0]         tx_data_q, tx_data_d;
    logic               tx_en_q, tx_en_d;
    logic               tx_er_q, tx_er_d;
    logic               busy_q, busy_d;
    logic               underrun_q, underrun_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic               take_byte, start_pad, start_fcs, frame_done, ur_evt;
    logic [10:0]        bcnt_inc;
    logic [31:0]        fcs_w, fcs_sh;
    logic [2:0]         fcs_idx;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        hold_hi_d   = hold_hi_q;
        last_d      = last_q;
        crc_d       = crc_q;
        bcnt_d      = bcnt_q;
        in_ready_d  = 1'b0;
        tx_data_d   = 4'h0;
        tx_en_d     = 1'b0;
        tx_er_d     = 1'b0;
        take_byte   = 1'b0;
        start_pad   = 1'b0;
        start_fcs   = 1'b0;
        frame_done  = 1'b0;
        ur_evt      = 1'b0;
        bcnt_inc    = (bcnt_q == BCNT_MAX) ? BCNT_MAX : bcnt_q + 11'd1;
        fcs_w       = ~crc_q;
        fcs_idx     = cnt_q[2:0] + 3'd1;
        fcs_sh      = fcs_w >> {fcs_idx, 2'b00};

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d   = S_PREAMBLE;
                    cnt_d     = '0;
                    crc_d     = CRC_INIT;
                    bcnt_d    = '0;
                    tx_en_d   = 1'b1;
                    tx_data_d = 4'h5;
                end
            end
            S_PREAMBLE: begin
                if (cnt_q < CNT_W'(14)) begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    tx_en_d   = 1'b1;
                    tx_data_d = 4'h5;
                end else if (cnt_q == CNT_W'(14)) begin
                    cnt_d      = CNT_W'(15);
                    tx_en_d    = 1'b1;
                    tx_data_d  = 4'hD;
                    in_ready_d = 1'b1;
                end else begin
                    take_byte = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (!phase_q) begin
                    phase_d    = 1'b1;
                    tx_en_d    = 1'b1;
                    tx_data_d  = hold_hi_q;
                    in_ready_d = !last_q;
                end else if (!last_q) begin
                    take_byte = 1'b1;
                end else if (int'(bcnt_q) < MIN_BYTES) begin
                    start_pad = 1'b1;
                end else begin
                    start_fcs = 1'b1;
                end
            end
            S_PAD: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    tx_en_d = 1'b1;
                end else if (int'(bcnt_q) < MIN_BYTES) begin
                    start_pad = 1'b1;
                end else begin
                    start_fcs = 1'b1;
                end
            end
            S_FCS: begin
                if (cnt_q < CNT_W'(7)) begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    tx_en_d   = 1'b1;
                    tx_data_d = fcs_sh[3:0];
                end else begin
                    state_d    = S_IFG;
                    cnt_d      = '0;
                    frame_done = 1'b1;
                end
            end
            S_UNDERRUN: begin
                state_d = S_IFG;
                cnt_d   = '0;
            end
            S_IFG: begin
                // The single IDLE cycle that follows is the last gap cycle, so
                // a waiting frame restarts exactly IFG_CYCLES after tx_en falls.
                if (int'(cnt_q) >= IFG_CYCLES - 2) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take_byte) begin
            if (in_valid) begin
                state_d   = S_PAYLOAD;
                phase_d   = 1'b0;
                hold_hi_d = in_data[7:4];
                last_d    = in_last;
                crc_d     = crc_byte(crc_q, in_data);
                bcnt_d    = bcnt_inc;
                tx_en_d   = 1'b1;
                tx_data_d = in_data[3:0];
            end else begin
                state_d = S_UNDERRUN;
                tx_en_d = 1'b1;
                tx_er_d = 1'b1;
                ur_evt  = 1'b1;
            end
        end
        if (start_pad) begin
            state_d = S_PAD;
            phase_d = 1'b0;
            crc_d   = crc_byte(crc_q, 8'h00);
            bcnt_d  = bcnt_inc;
            tx_en_d = 1'b1;
        end
        if (start_fcs) begin
            state_d   = S_FCS;
            cnt_d     = '0;
            tx_en_d   = 1'b1;
            tx_data_d = fcs_w[3:0];
        end

        // Status events take priority over a same-cycle clear.
        underrun_d  = clr_status ? 1'b0 : underrun_q;
        frame_cnt_d = clr_status ? 16'h0 : frame_cnt_q;
        if (ur_evt) begin
            underrun_d = 1'b1;
        end
        if (frame_done) begin
            frame_cnt_d = frame_cnt_d + 16'd1;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            hold_hi_q   <= 4'h0;
            last_q      <= 1'b0;
            crc_q       <= CRC_INIT;
            bcnt_q      <= '0;
            in_ready_q  <= 1'b0;
            tx_data_q   <= 4'h0;
            tx_en_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
            frame_cnt_q <= 16'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            hold_hi_q   <= hold_hi_d;
            last_q      <= last_d;
            crc_q       <= crc_d;
            bcnt_q      <= bcnt_d;
            in_ready_q  <= in_ready_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
            tx_er_q     <= tx_er_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign tx_data   = tx_data_q;
    assign tx_en     = tx_en_q;
    assign tx_er     = tx_er_q;
    assign busy      = busy_q;
    assign underrun  = underrun_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_eth_mii_tx_framer.sv
// Purpose: directed self-checking bench for eth_mii_tx_framer (one instance with padding off, one with MIN_BYTES=60).
// Latency: checks preamble timing, frame lengths, FCS values and the inter-frame gap.
// Backpressure: the driver follows in_ready pulses; the underrun case withholds in_valid mid-frame.
module tb_eth_mii_tx_framer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, in_valid, in_last, clr_status, sel0;
    logic [7:0]  in_data;
    logic        rdy0, en0, er0, busy0, ur0;
    logic [3:0]  txd0;
    logic [15:0] fc0;
    logic        rdy1, en1, er1, busy1, ur1;
    logic [3:0]  txd1;
    logic [15:0] fc1;
    logic        rdy_s, txen_s, txer_s, busy_s;
    logic [3:0]  txd_s;

    eth_mii_tx_framer #(.MIN_BYTES(0), .IFG_CYCLES(24)) u_dut0 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid & sel0), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy0), .tx_data(txd0), .tx_en(en0), .tx_er(er0),
        .busy(busy0), .underrun(ur0), .clr_status(clr_status), .frame_cnt(fc0));

    eth_mii_tx_framer #(.MIN_BYTES(60), .IFG_CYCLES(24)) u_dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid & ~sel0), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy1), .tx_data(txd1), .tx_en(en1), .tx_er(er1),
        .busy(busy1), .underrun(ur1), .clr_status(clr_status), .frame_cnt(fc1));

    assign rdy_s  = sel0 ? rdy0  : rdy1;
    assign txen_s = sel0 ? en0   : en1;
    assign txer_s = sel0 ? er0   : er1;
    assign busy_s = sel0 ? busy0 : busy1;
    assign txd_s  = sel0 ? txd0  : txd1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] nib_q[$];
    logic [3:0] exp_q[$];
    int cap_len, cap_rdy, cap_consec, cap_first_rdy, cap_er_idx;
    logic cap_busy;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    task automatic build_exp(input int n, input logic [7:0] seed, input logic [7:0] step, input int minb);
        logic [31:0] c;
        logic [7:0]  b;
        int          cnt;
        c = 32'hFFFFFFFF;
        exp_q.delete();
        for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        for (int i = 0; i < n; i++) begin
            b = seed + 8'(i) * step;
            exp_q.push_back(b[3:0]);
            exp_q.push_back(b[7:4]);
            c = crc_upd(c, b);
        end
        cnt = n;
        while (cnt < minb) begin
            exp_q.push_back(4'h0);
            exp_q.push_back(4'h0);
            c = crc_upd(c, 8'h00);
            cnt++;
        end
        c = ~c;
        for (int k = 0; k < 8; k++) exp_q.push_back(c[4*k +: 4]);
    endtask

    function automatic int mism_prefix(input int k);
        int m = 0;
        for (int i = 0; i < k; i++) begin
            if (i >= nib_q.size() || i >= exp_q.size()) m++;
            else if (nib_q[i] !== exp_q[i]) m++;
        end
        return m;
    endfunction

    task automatic drive_frame(input int n, input int drop_at, input logic [7:0] seed, input logic [7:0] step);
        int   idx = 0;
        int   cyc = 0;
        logic pend = 1'b0;
        while (idx < n) begin
            @(negedge clk);
            cyc++;
            if (pend) idx++;
            pend = 1'b0;
            if (idx == drop_at || idx >= n) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = 8'h00;
                if (idx == drop_at) break;
            end else begin
                in_valid = 1'b1;
                in_data  = seed + 8'(idx) * step;
                in_last  = (idx == n - 1);
                pend     = rdy_s;
            end
            if (cyc > 4000) begin
                check("drv_timeout", 32'(idx), 32'(n));
                break;
            end
        end
    endtask

    task automatic capture(input int clr_at);
        int   w = 0;
        logic prev_rdy = 1'b0;
        nib_q.delete();
        cap_len = 0; cap_rdy = 0; cap_consec = 0; cap_first_rdy = -1; cap_er_idx = -1; cap_busy = 1'b0;
        while (!txen_s && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (!txen_s) begin
            check("cap_start_timeout", {31'h0, txen_s}, 32'h1);
            return;
        end
        cap_busy = busy_s;
        while (txen_s && cap_len < 3000) begin
            nib_q.push_back(txd_s);
            if (rdy_s) begin
                cap_rdy++;
                if (cap_first_rdy < 0) cap_first_rdy = cap_len;
                if (prev_rdy) cap_consec++;
            end
            prev_rdy = rdy_s;
            if (txer_s && cap_er_idx < 0) cap_er_idx = cap_len;
            clr_status = (cap_len == clr_at);
            cap_len++;
            @(negedge clk);
        end
        clr_status = 1'b0;
    endtask

    task automatic measure_gap(output int g, input int lim);
        g = 0;
        while (!txen_s && g < lim) begin
            g++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g;
        logic [31:0] f;
        resetn = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        clr_status = 1'b0; sel0 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_en", {31'h0, en1}, 32'h0);
        check("rst_outs", {16'h0, rdy1, txd1, er1, busy1, ur1, 8'h0} | {16'h0, fc1}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_after_rst", {27'h0, rdy1, en1, er1, busy1, ur1}, 32'h0);

        // "123456789" with padding disabled
        sel0 = 1'b1;
        fork
            drive_frame(9, -1, 8'h31, 8'h01);
            begin build_exp(9, 8'h31, 8'h01, 0); capture(-1); end
        join
        check("t1_len", 32'(cap_len), 32'd42);
        check("t1_nibbles", 32'(mism_prefix(42)), 32'd0);
        f = 32'h0;
        if (nib_q.size() >= 42) for (int k = 0; k < 8; k++) f[4*k +: 4] = nib_q[34 + k];
        check("t1_fcs", f, 32'hCBF43926);
        check("t1_first_rdy", 32'(cap_first_rdy), 32'd15);
        check("t1_rdy_pulses", 32'(cap_rdy), 32'd9);
        check("t1_busy", {31'h0, cap_busy}, 32'h1);
        check("t1_frame_cnt", {16'h0, fc0}, 32'd1);
        sel0 = 1'b0;

        // single byte padded to 60
        fork
            drive_frame(1, -1, 8'hAB, 8'h00);
            begin build_exp(1, 8'hAB, 8'h00, 60); capture(-1); end
        join
        check("t2_len", 32'(cap_len), 32'd144);
        check("t2_nibbles", 32'(mism_prefix(144)), 32'd0);
        check("t2_frame_cnt", {16'h0, fc1}, 32'd1);
        measure_gap(g, 40);
        check("t2_busy_idle", {31'h0, busy1}, 32'h0);
        pulse_clr();
        check("clr_frame_cnt", {16'h0, fc1}, 32'd0);

        // back-to-back 64-byte frames
        fork
            begin drive_frame(64, -1, 8'h10, 8'h03); drive_frame(64, -1, 8'h80, 8'h05); end
            begin
                build_exp(64, 8'h10, 8'h03, 60); capture(-1);
                check("t3a_len", 32'(cap_len), 32'd152);
                check("t3a_nibbles", 32'(mism_prefix(152)), 32'd0);
                check("t3a_rdy_pulses", 32'(cap_rdy), 32'd64);
                check("t3a_rdy_consec", 32'(cap_consec), 32'd0);
                measure_gap(g, 100);
                check("t3_gap", 32'(g), 32'd24);
                build_exp(64, 8'h80, 8'h05, 60); capture(-1);
                check("t3b_len", 32'(cap_len), 32'd152);
                check("t3b_nibbles", 32'(mism_prefix(152)), 32'd0);
                check("t3b_rdy_pulses", 32'(cap_rdy), 32'd64);
            end
        join
        check("t3_frame_cnt", {16'h0, fc1}, 32'd2);

        // underrun at byte 10 of a 70-byte frame
        fork
            drive_frame(70, 10, 8'h20, 8'h01);
            begin build_exp(70, 8'h20, 8'h01, 60); capture(-1); end
        join
        check("t4_len", 32'(cap_len), 32'd37);
        check("t4_er_idx", 32'(cap_er_idx), 32'd36);
        check("t4_prefix", 32'(mism_prefix(36)), 32'd0);
        measure_gap(g, 40);
        check("t4_gap_min", {31'h0, g >= 24}, 32'h1);
        check("t4_underrun", {31'h0, ur1}, 32'h1);
        check("t4_frame_cnt", {16'h0, fc1}, 32'd2);
        pulse_clr();
        check("t4_clr_underrun", {31'h0, ur1}, 32'h0);
        check("t4_clr_frame_cnt", {16'h0, fc1}, 32'd0);

        // reset in the middle of the payload
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0;
        repeat (40) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("t5_rst_tx_en", {31'h0, en1}, 32'h0);
        check("t5_rst_outs", {25'h0, rdy1, txd1, er1, busy1}, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        fork
            drive_frame(60, -1, 8'h01, 8'h11);
            begin build_exp(60, 8'h01, 8'h11, 60); capture(-1); end
        join
        check("t5_len", 32'(cap_len), 32'd144);
        check("t5_nibbles", 32'(mism_prefix(144)), 32'd0);
        check("t5_frame_cnt", {16'h0, fc1}, 32'd1);
        measure_gap(g, 40);

        // clear in the same cycle as frame completion
        fork
            drive_frame(60, -1, 8'h40, 8'h02);
            begin build_exp(60, 8'h40, 8'h02, 60); capture(143); end
        join
        check("t6_len", 32'(cap_len), 32'd144);
        check("t6_frame_cnt", {16'h0, fc1}, 32'd1);
        measure_gap(g, 40);

        // frame counter wrap
        force u_dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1 release u_dut.frame_cnt_q;
        @(negedge clk);
        check("t7_preload", {16'h0, fc1}, 32'h0000FFFF);
        fork
            drive_frame(60, -1, 8'h77, 8'h01);
            capture(-1);
        join
        check("t7_wrap", {16'h0, fc1}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
